dec_cs_sequencer: RTL and testbench
===================================

Name: dec_cs_sequencer

Overview:
- Round-robin arbiter and strobe sequencer for the 3-to-8 active-low chip-select decoder.
- Eight requesters compete for the decoder; the winner's index drives select A/B/C.
- The three decoder enables are strobed with programmable setup, active and hold phases, so exactly one decoder output pulses low per transaction.
- Sits between the requesting peripherals' bus masters and the decoder instance.

Parameters:
- SETUP_CYC, 1, cycles select lines are stable before enables assert (1..15).
- HOLD_CYC, 1, cycles select lines are held after enables deassert (1..15).
- LEN_W, 4, width of strobe_len_i.

Ports:
- clk_i  input  1  system clock, rising edge
- rst_i  input  1  asynchronous reset, active-high
- req_i  input  8  request vector, bit k = requester k
- strobe_len_i  input  LEN_W  active-phase length minus one; sampled at grant
- grant_o  output  8  one-hot grant, held for the whole transaction
- busy_o  output  1  high in any non-IDLE state
- done_o  output  1  one-cycle pulse on the last HOLD cycle
- select_a_o  output  1  decoder select bit 0 (LSB of granted index)
- select_b_o  output  1  decoder select bit 1
- select_c_o  output  1  decoder select bit 2
- g1_en_o  output  1  decoder enable, active-high
- g2a_en_n_o  output  1  decoder enable, active-low
- g2b_en_n_o  output  1  decoder enable, active-low

Behaviour:
- Reset, asynchronous and immediate:
  - state = IDLE, grant_o = 0, busy_o = 0, done_o = 0.
  - select_c/b/a_o = 000, g1_en_o = 0, g2a_en_n_o = 1, g2b_en_n_o = 1.
  - RR pointer = 7, so requester 0 has highest priority first.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - On a clock edge with req_i != 0, select the winner: the first set bit searching upward from pointer+1, wrapping 7 to 0.
  - Load grant_o = one-hot(winner) and select = winner.
  - Latch strobe_len_i, update pointer = winner, go to SETUP.
  - Enables stay inactive.
- SETUP:
  - Lasts SETUP_CYC cycles; enables inactive; select and grant stable.
- STROBE:
  - Lasts latched_len+1 cycles, range 1..16 for LEN_W = 4.
  - Enables active: g1 = 1, g2a_n = 0, g2b_n = 0.
- HOLD:
  - Lasts HOLD_CYC cycles; enables inactive; select and grant held.
  - done_o = 1 on the final HOLD cycle only.
  - Next state IDLE; grant_o and select clear on entering IDLE.
- Minimum transaction = SETUP_CYC + 1 + HOLD_CYC cycles, plus one IDLE cycle between transactions (without DEC_B2B_EN).
- Enables are only ever active in STROBE, so select lines never change while enables are active.
- req_i changes during a transaction are ignored. Deassertion by the grantee does not abort; the transaction completes.
- Multiple simultaneous requests are served by the rotating pointer. A continuously requesting master waits at most 7 transactions.
- strobe_len_i changes after grant have no effect on the current transaction.
- Phase counter width: max(LEN_W, 4) bits; it reloads on every state entry.

Optional Feature:
- Macro DEC_B2B_EN.
- Defined: on the final HOLD cycle, if req_i != 0, arbitrate exactly as in IDLE and go directly to SETUP with the new grant.
  - busy_o stays high and IDLE is skipped.
  - done_o still pulses for the completing transaction.
- Undefined: always return to IDLE after HOLD, as described in Behaviour.

Test Plan:
- Reset mid-STROBE: assert rst_i during the enable phase -> enables go to 0/1/1, grant_o = 00h and busy_o = 0 immediately, with no clock edge needed.
- Single request: req_i = 08h, strobe_len_i = 2, defaults, observed from the grant edge:
  - 1 SETUP cycle with select = 011 and enables inactive.
  - 3 cycles of g1 = 1, g2a_n = 0, g2b_n = 0.
  - 1 HOLD cycle with done_o = 1.
  - Then IDLE with grant_o = 00h.
- Round-robin: req_i = 81h held high, four transactions -> grant order 01h, 80h, 01h, 80h.
- Wrap search: after serving requester 6, req_i = 05h -> grant 01h, then 04h.
- Length latch: strobe_len_i = 0 at grant, changed to Fh during SETUP -> STROBE lasts exactly 1 cycle.
- With DEC_B2B_EN: req_i = 03h held -> grant 01h then 02h with no IDLE cycle between; busy_o continuously high; done_o pulses once per transaction.

Source files
------------

// File: rtl/dec_cs_sequencer.sv
// Round-robin arbiter and setup/strobe/hold sequencer driving a 3-to-8 active-low chip-select decoder.
// Latency: grant, select and busy register on the edge that sees a request; enables follow SETUP_CYC cycles later.
// Backpressure: requests arriving mid-transaction wait; one IDLE gap separates transactions unless DEC_B2B_EN is defined.
// Optional feature macro: DEC_B2B_EN (re-arbitrate on the final HOLD cycle, skipping IDLE).
module dec_cs_sequencer #(
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int LEN_W     = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       req_i,
  input  logic [LEN_W-1:0] strobe_len_i,
  output logic [7:0]       grant_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             select_a_o,
  output logic             select_b_o,
  output logic             select_c_o,
  output logic             g1_en_o,
  output logic             g2a_en_n_o,
  output logic             g2b_en_n_o
);

  localparam int CNT_W = (LEN_W > 4) ? LEN_W : 4;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ptr_q;
  logic [LEN_W-1:0] len_q;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       grant_d;
  logic             busy_d, done_d, strobe_d;

  logic             arb_vld;
  logic [2:0]       win_idx;
  logic [2:0]       cand;
  logic             take;

  // Round-robin search: first set request strictly after the pointer, wrapping 7 -> 0.
  always_comb begin
    arb_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!arb_vld && req_i[cand]) begin
        arb_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // State register plus phase counter, pointer and latched strobe length.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 3'd7;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        ptr_q <= win_idx;
        len_q <= strobe_len_i;
      end
    end
  end

  // Next-state logic: counter reloads on every phase entry and counts down to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          take    = 1'b1;
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = CNT_W'(len_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
`ifdef DEC_B2B_EN
          if (arb_vld) begin
            take    = 1'b1;
            state_d = SETUP;
            cnt_d   = CNT_W'(SETUP_CYC - 1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
`else
          state_d = IDLE;
          cnt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    busy_d   = (state_d != IDLE);
    strobe_d = (state_d == STROBE);
    done_d   = (state_d == HOLD) && (cnt_d == '0);
    if (take) begin
      grant_d = 8'b1 << win_idx;
      sel_d   = win_idx;
    end else if (state_d == IDLE) begin
      grant_d = '0;
      sel_d   = '0;
    end else begin
      grant_d = grant_o;
      sel_d   = sel_q;
    end
  end

  // Output registers; enables are only active in STROBE so select never moves under them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_o    <= '0;
      sel_q      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      g1_en_o    <= 1'b0;
      g2a_en_n_o <= 1'b1;
      g2b_en_n_o <= 1'b1;
    end else begin
      grant_o    <= grant_d;
      sel_q      <= sel_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      g1_en_o    <= strobe_d;
      g2a_en_n_o <= ~strobe_d;
      g2b_en_n_o <= ~strobe_d;
    end
  end

  assign select_a_o = sel_q[0];
  assign select_b_o = sel_q[1];
  assign select_c_o = sel_q[2];

endmodule

// File: tb/tb_dec_cs_sequencer.sv
// Directed bench for dec_cs_sequencer: table of transactions plus hand sequences for reset and back-to-back.
// Latency: checks are sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: every wait on the DUT is bounded by a cycle budget.
module tb_dec_cs_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] req_i;
  logic [3:0] strobe_len_i;
  logic [7:0] grant_o;
  logic       busy_o, done_o;
  logic       select_a_o, select_b_o, select_c_o;
  logic       g1_en_o, g2a_en_n_o, g2b_en_n_o;

  dec_cs_sequencer #(.SETUP_CYC(1), .HOLD_CYC(1), .LEN_W(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .strobe_len_i (strobe_len_i),
    .grant_o      (grant_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .select_a_o   (select_a_o),
    .select_b_o   (select_b_o),
    .select_c_o   (select_c_o),
    .g1_en_o      (g1_en_o),
    .g2a_en_n_o   (g2a_en_n_o),
    .g2b_en_n_o   (g2b_en_n_o)
  );

  always #5 clk_i = ~clk_i;

  wire [2:0] sel = {select_c_o, select_b_o, select_a_o};

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] req;
    logic [3:0] len;
    logic [7:0] exp_grant;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] idx_of(input logic [7:0] g);
    idx_of = '0;
    for (int i = 0; i < 8; i++) if (g[i]) idx_of = 3'(i);
  endfunction

  // One full transaction: request at a falling edge, dropped right after grant, length scrambled during SETUP.
  task automatic run_txn(input logic [7:0] req, input logic [3:0] len, input logic [7:0] eg);
    int setup_n, strobe_n, hold_n, done_n, done_bad, hold_bad, en_bad;
    bit fin;
    @(negedge clk_i);
    req_i = req;
    strobe_len_i = len;
    @(negedge clk_i);
    chk("grant", 32'(grant_o), 32'(eg));
    chk("select", 32'(sel), 32'(idx_of(eg)));
    chk("busy_at_grant", 32'(busy_o), 32'd1);
    chk("setup_en", 32'({g1_en_o, g2a_en_n_o, g2b_en_n_o}), 32'b011);
    req_i = 8'h00;
    strobe_len_i = ~len;
    setup_n = 1; strobe_n = 0; hold_n = 0; done_n = 0;
    done_bad = 0; hold_bad = 0; en_bad = 0; fin = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_i);
      if (!busy_o) begin
        fin = 1'b1;
        break;
      end
      if (grant_o !== eg || sel !== idx_of(eg)) hold_bad++;
      if (g1_en_o) begin
        strobe_n++;
        if (g2a_en_n_o !== 1'b0 || g2b_en_n_o !== 1'b0) en_bad++;
      end else begin
        if (g2a_en_n_o !== 1'b1 || g2b_en_n_o !== 1'b1) en_bad++;
        if (strobe_n == 0) setup_n++;
        else hold_n++;
      end
      if (done_o) begin
        done_n++;
        if (g1_en_o || strobe_n == 0) done_bad++;
      end
    end
    chk("txn_finished", 32'(fin), 32'd1);
    chk("setup_cycles", 32'(setup_n), 32'd1);
    chk("strobe_cycles", 32'(strobe_n), 32'(len) + 32'd1);
    chk("hold_cycles", 32'(hold_n), 32'd1);
    chk("done_pulses", 32'(done_n), 32'd1);
    chk("done_place", 32'(done_bad), 32'd0);
    chk("grant_sel_held", 32'(hold_bad), 32'd0);
    chk("enable_pattern", 32'(en_bad), 32'd0);
    chk("idle_grant", 32'(grant_o), 32'h00);
    chk("idle_select", 32'(sel), 32'd0);
  endtask

  initial begin
    int done_n;
    bit fin, busy_gap;
    rst_i = 1'b1;
    req_i = 8'h00;
    strobe_len_i = 4'h0;

    vecs[0] = '{8'h81, 4'h1, 8'h01};
    vecs[1] = '{8'h81, 4'h0, 8'h80};
    vecs[2] = '{8'h81, 4'h3, 8'h01};
    vecs[3] = '{8'h81, 4'h0, 8'h80};
    vecs[4] = '{8'h08, 4'h2, 8'h08};
    vecs[5] = '{8'h40, 4'h3, 8'h40};
    vecs[6] = '{8'h05, 4'h0, 8'h01};
    vecs[7] = '{8'h05, 4'h1, 8'h04};
    vecs[8] = '{8'hFF, 4'hF, 8'h08};
    vecs[9] = '{8'hFF, 4'h0, 8'h10};

    #1;
    chk("rst_grant", 32'(grant_o), 32'h00);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_select", 32'(sel), 32'd0);
    chk("rst_en", 32'({g1_en_o, g2a_en_n_o, g2b_en_n_o}), 32'b011);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int v = 0; v < 10; v++) run_txn(vecs[v].req, vecs[v].len, vecs[v].exp_grant);

    // Reset asserted in the middle of the enable phase clears outputs without a clock edge.
    @(negedge clk_i);
    req_i = 8'h20;
    strobe_len_i = 4'h5;
    @(negedge clk_i);
    req_i = 8'h00;
    fin = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (g1_en_o) begin
        fin = 1'b1;
        break;
      end
    end
    chk("reached_strobe", 32'(fin), 32'd1);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_en", 32'({g1_en_o, g2a_en_n_o, g2b_en_n_o}), 32'b011);
    chk("midrst_grant", 32'(grant_o), 32'h00);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run_txn(8'hFF, 4'h0, 8'h01);

    // Held request 03h after serving requester 0: next is requester 1, then requester 0.
    @(negedge clk_i);
    req_i = 8'h03;
    strobe_len_i = 4'h0;
    @(negedge clk_i);
    chk("held_first_grant", 32'(grant_o), 32'h02);
    done_n = 0;
    busy_gap = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (!busy_o) busy_gap = 1'b1;
      if (done_o) done_n++;
      if (grant_o != 8'h02) begin
        fin = 1'b1;
        break;
      end
    end
    chk("held_left_first", 32'(fin), 32'd1);
    chk("held_done_first", 32'(done_n), 32'd1);
`ifdef DEC_B2B_EN
    chk("b2b_no_idle", 32'(busy_gap), 32'd0);
    chk("b2b_second_grant", 32'(grant_o), 32'h01);
    chk("b2b_busy", 32'(busy_o), 32'd1);
`else
    chk("gap_idle", 32'(busy_gap), 32'd1);
    chk("gap_grant_clear", 32'(grant_o), 32'h00);
    @(negedge clk_i);
    chk("gap_second_grant", 32'(grant_o), 32'h01);
    chk("gap_busy", 32'(busy_o), 32'd1);
`endif
    req_i = 8'h00;
    done_n = 0;
    fin = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (done_o) done_n++;
      if (!busy_o) begin
        fin = 1'b1;
        break;
      end
    end
    chk("held_second_end", 32'(fin), 32'd1);
    chk("held_done_second", 32'(done_n), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
